// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction memory read port, decoder-facing instruction
// port and the branch/jump redirect input.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misaligned;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, misaligned,
    input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, misaligned,
    output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding req/ack read, holds the fetched word for
// the decoder, drives NOP when empty, and flushes stale fetches on PC redirect.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] fetch_pc_r;
  logic [31:0] addr_r;
  logic [31:0] instr_r;
  logic [31:0] instr_pc_r;
  logic        req_r;
  logic        valid_r;
  logic        misaligned_r;
  logic [31:0] redirect_target_s;

  assign redirect_target_s = {bus.redirect_pc[31:2], 2'b00};

  // Fetch FSM; addr_r only moves when a new request starts, so it stays put while req is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      fetch_pc_r   <= RESET_PC;
      addr_r       <= RESET_PC;
      req_r        <= 1'b0;
      instr_r      <= NOP_INSTR;
      instr_pc_r   <= RESET_PC;
      valid_r      <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      misaligned_r <= 1'b0;
      if (bus.redirect_valid) begin
        fetch_pc_r   <= redirect_target_s;
        valid_r      <= 1'b0;
        instr_r      <= NOP_INSTR;
        misaligned_r <= |bus.redirect_pc[1:0];
        case (state_r)
          S_IDLE: begin
            state_r <= S_IDLE;
            req_r   <= 1'b0;
          end
          S_HOLD: begin
            state_r <= S_REQ;
            req_r   <= 1'b1;
            addr_r  <= redirect_target_s;
          end
          S_REQ, S_FLUSH: begin
            // The in-flight read must complete before the new address goes out.
            if (bus.imem_ack) begin
              state_r <= S_REQ;
              addr_r  <= redirect_target_s;
            end else begin
              state_r <= S_FLUSH;
            end
            req_r <= 1'b1;
          end
          default: begin
            state_r <= S_IDLE;
            req_r   <= 1'b0;
          end
        endcase
      end else begin
        case (state_r)
          S_IDLE: begin
            state_r <= S_REQ;
            req_r   <= 1'b1;
            addr_r  <= fetch_pc_r;
          end
          S_REQ: begin
            if (bus.imem_ack) begin
              instr_r    <= bus.imem_rdata;
              instr_pc_r <= fetch_pc_r;
              valid_r    <= 1'b1;
              fetch_pc_r <= fetch_pc_r + 32'd4;
              state_r    <= S_HOLD;
              req_r      <= 1'b0;
            end else begin
              state_r <= S_REQ;
              req_r   <= 1'b1;
            end
          end
          S_HOLD: begin
            if (bus.instr_ready) begin
              valid_r <= 1'b0;
              instr_r <= NOP_INSTR;
              state_r <= S_REQ;
              req_r   <= 1'b1;
              addr_r  <= fetch_pc_r;
            end else begin
              state_r <= S_HOLD;
              req_r   <= 1'b0;
            end
          end
          S_FLUSH: begin
            // fetch_pc_r already holds the redirect target; the returning data is stale.
            if (bus.imem_ack) begin
              state_r <= S_REQ;
              addr_r  <= fetch_pc_r;
            end else begin
              state_r <= S_FLUSH;
            end
            req_r <= 1'b1;
          end
          default: begin
            state_r <= S_IDLE;
            req_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.imem_req    = req_r;
  assign bus.imem_addr   = addr_r;
  assign bus.instr       = instr_r;
  assign bus.instr_pc    = instr_pc_r;
  assign bus.instr_valid = valid_r;
  assign bus.misaligned  = misaligned_r;

endmodule
